// File: rtl/dac_sweep_pkg.sv
// Shared types and constants for the bias DAC sweep sequencer.
package dac_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SPI,
    DWELL,
    NEXT,
    FINISH
  } state_t;

  localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
  localparam int unsigned CMD_W_DEF        = 4;
  localparam int unsigned DATA_W_DEF       = 12;
  localparam int unsigned FRAME_W          = CMD_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/dac_sweep_sequencer_dac_dwell_timer.sv
// Loadable down-counter; expired pulses for one cycle on the last held cycle.
module dac_dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Decoded from cnt==1 so a load of N keeps the caller waiting exactly N cycles.
  assign expired = (cnt == W'(1)) && !load;

endmodule

// File: rtl/dac_sweep_sequencer.sv
// Steps the bias DAC from start to stop through the SPI write path.
// Build option: DAC_SWEEP_RETURN_ZERO_EN appends a final code-0 frame.
module dac_sweep_sequencer
  import dac_sweep_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CMD_W   = CMD_W_DEF,
  parameter int unsigned DWELL_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [DATA_W-1:0]       code_start_i,
  input  logic [DATA_W-1:0]       code_stop_i,
  input  logic [DATA_W-1:0]       step_i,
  input  logic [DWELL_W-1:0]      dwell_i,
  output logic                    spi_start_o,
  output logic [CMD_W+DATA_W-1:0] spi_data_o,
  input  logic                    spi_done_i,
  output logic [DATA_W-1:0]       code_o,
  output logic                    busy_o,
  output logic                    eov_o,
  output logic                    done_o
);

  localparam logic [CMD_W-1:0]  CMD       = CMD_W'(CMD_WRITE_UPDATE);
  localparam logic [DATA_W-1:0] ZERO_CODE = '0;

  state_t              state;
  logic [DATA_W-1:0]   cur;
  logic [DATA_W-1:0]   stop_q;
  logic [DATA_W-1:0]   step_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic                abort_pend;
  logic [DATA_W:0]     nxt;
  logic                last_point;
  logic                abort_now;
  logic                tload;
  logic                dwell_done;
`ifdef DAC_SWEEP_RETURN_ZERO_EN
  logic                rz_q;
`endif

  always_comb begin
    nxt        = {1'b0, cur} + {1'b0, step_q};
    last_point = (step_q == '0) || nxt[DATA_W] || (nxt[DATA_W-1:0] > stop_q);
    abort_now  = abort_pend || abort_i;
    tload      = (state == WAIT_SPI) && spi_done_i;
  end

  dac_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (tload),
    .value   (dwell_q),
    .expired (dwell_done)
  );

  // Frame outputs are loaded on the edge that enters SEND so spi_start_o
  // appears one cycle after the accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cur         <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      abort_pend  <= 1'b0;
      spi_start_o <= 1'b0;
      spi_data_o  <= '0;
      code_o      <= '0;
      busy_o      <= 1'b0;
      eov_o       <= 1'b0;
      done_o      <= 1'b0;
`ifdef DAC_SWEEP_RETURN_ZERO_EN
      rz_q        <= 1'b0;
`endif
    end else begin
      spi_start_o <= 1'b0;
      eov_o       <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            stop_q      <= code_stop_i;
            step_q      <= step_i;
            dwell_q     <= dwell_i;
            cur         <= code_start_i;
            abort_pend  <= 1'b0;
            spi_start_o <= 1'b1;
            spi_data_o  <= {CMD, code_start_i};
            code_o      <= code_start_i;
            busy_o      <= 1'b1;
            state       <= SEND;
`ifdef DAC_SWEEP_RETURN_ZERO_EN
            rz_q        <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (abort_i) abort_pend <= 1'b1;
          state <= WAIT_SPI;
        end
        WAIT_SPI: begin
          if (spi_done_i) begin
`ifdef DAC_SWEEP_RETURN_ZERO_EN
            if (rz_q) begin
              if (abort_now) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                done_o <= 1'b1;
                state  <= FINISH;
              end
            end else if (abort_now) begin
              eov_o       <= 1'b1;
              abort_pend  <= 1'b1;
              rz_q        <= 1'b1;
              spi_start_o <= 1'b1;
              spi_data_o  <= {CMD, ZERO_CODE};
              code_o      <= ZERO_CODE;
              state       <= SEND;
            end else begin
              eov_o <= 1'b1;
              state <= (dwell_q == '0) ? NEXT : DWELL;
            end
`else
            eov_o <= 1'b1;
            if (abort_now) begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= (dwell_q == '0) ? NEXT : DWELL;
            end
`endif
          end else if (abort_i) begin
            abort_pend <= 1'b1;
          end
        end
        DWELL: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (dwell_done) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (last_point) begin
`ifdef DAC_SWEEP_RETURN_ZERO_EN
            rz_q        <= 1'b1;
            spi_start_o <= 1'b1;
            spi_data_o  <= {CMD, ZERO_CODE};
            code_o      <= ZERO_CODE;
            state       <= SEND;
`else
            done_o <= 1'b1;
            state  <= FINISH;
`endif
          end else begin
            cur         <= nxt[DATA_W-1:0];
            spi_start_o <= 1'b1;
            spi_data_o  <= {CMD, nxt[DATA_W-1:0]};
            code_o      <= nxt[DATA_W-1:0];
            state       <= SEND;
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Directed bench for dac_sweep_sequencer with a behavioural SPI master.
module tb_dac_sweep_sequencer;
  import dac_sweep_pkg::*;

  localparam int unsigned DW = 12;
  localparam int unsigned TW = 16;
`ifdef DAC_SWEEP_RETURN_ZERO_EN
  localparam bit RZ = 1'b1;
`else
  localparam bit RZ = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic [DW-1:0]      code_start_i = '0;
  logic [DW-1:0]      code_stop_i = '0;
  logic [DW-1:0]      step_i = '0;
  logic [TW-1:0]      dwell_i = '0;
  logic               spi_start_o;
  logic [FRAME_W-1:0] spi_data_o;
  logic               spi_done_i = 1'b0;
  logic [DW-1:0]      code_o;
  logic               busy_o;
  logic               eov_o;
  logic               done_o;

  always #5 clk = ~clk;

  dac_sweep_sequencer #(.DATA_W(DW), .CMD_W(4), .DWELL_W(TW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .code_start_i (code_start_i),
    .code_stop_i  (code_stop_i),
    .step_i       (step_i),
    .dwell_i      (dwell_i),
    .spi_start_o  (spi_start_o),
    .spi_data_o   (spi_data_o),
    .spi_done_i   (spi_done_i),
    .code_o       (code_o),
    .busy_o       (busy_o),
    .eov_o        (eov_o),
    .done_o       (done_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_eov = 0;
  int n_done = 0;
  int last_done_cyc = -1;
  int min_gap = 1000;
  logic [FRAME_W-1:0] frames[$];
  logic [DW-1:0]      exp_codes[$];

  // SPI master: done pulse three cycles after each frame request.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_start_o) begin
        repeat (3) @(posedge clk);
        #1 spi_done_i = 1'b1;
        @(posedge clk);
        #1 spi_done_i = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (spi_start_o) begin
      frames.push_back(spi_data_o);
      if (last_done_cyc >= 0 && (cyc - last_done_cyc) < min_gap) min_gap = cyc - last_done_cyc;
    end
    if (spi_done_i) last_done_cyc = cyc;
    if (eov_o) n_eov = n_eov + 1;
    if (done_o) n_done = n_done + 1;
  end

  task automatic clr();
    frames.delete();
    exp_codes.delete();
    n_eov = 0;
    n_done = 0;
    last_done_cyc = -1;
    min_gap = 1000;
  endtask

  task automatic kick(input logic [DW-1:0] s, input logic [DW-1:0] e,
                      input logic [DW-1:0] st, input logic [TW-1:0] d);
    @(negedge clk);
    code_start_i = s;
    code_stop_i  = e;
    step_i       = st;
    dwell_i      = d;
    start_i      = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 4000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout busy=%b required 0", busy_o);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    total += 6;
    if (spi_start_o !== 1'b0) begin bad++; $display("FAIL rst_spi_start got %b want 0", spi_start_o); end
    if (spi_data_o !== 16'h0) begin bad++; $display("FAIL rst_spi_data got %h want 0000", spi_data_o); end
    if (code_o !== 12'h0) begin bad++; $display("FAIL rst_code got %h want 000", code_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy_o); end
    if (eov_o !== 1'b0) begin bad++; $display("FAIL rst_eov got %b want 0", eov_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_abort();
    clr();
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    total += 2;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL startabort_busy got %b want 0", busy_o); end
    if (spi_start_o !== 1'b0) begin bad++; $display("FAIL startabort_spi got %b want 0", spi_start_o); end
    repeat (3) @(negedge clk);
    total++;
    if (frames.size() != 0) begin bad++; $display("FAIL startabort_frames got %0d want 0", frames.size()); end
  endtask

  task automatic test_sweep_dwell();
    clr();
    kick(12'd100, 12'd130, 12'd10, 16'd5);
    total += 3;
    if (spi_start_o !== 1'b1) begin bad++; $display("FAIL latency_spi_start got %b want 1", spi_start_o); end
    if (code_o !== 12'd100) begin bad++; $display("FAIL latency_code got %0d want 100", code_o); end
    if (busy_o !== 1'b1) begin bad++; $display("FAIL latency_busy got %b want 1", busy_o); end
    repeat (3) @(negedge clk);
    code_start_i = 12'd7;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();
    exp_codes = '{12'd100, 12'd110, 12'd120, 12'd130};
    if (RZ) exp_codes.push_back(12'd0);
    total++;
    if (frames.size() != exp_codes.size()) begin bad++; $display("FAIL dwell_nframes got %0d want %0d", frames.size(), exp_codes.size()); end
    for (int i = 0; i < exp_codes.size() && i < frames.size(); i++) begin
      total++;
      if (frames[i] !== {4'b0011, exp_codes[i]}) begin bad++; $display("FAIL dwell_frame%0d got %h want %h", i, frames[i], {4'b0011, exp_codes[i]}); end
    end
    total += 4;
    if (n_eov != 4) begin bad++; $display("FAIL dwell_eov got %0d want 4", n_eov); end
    if (n_done != 1) begin bad++; $display("FAIL dwell_done got %0d want 1", n_done); end
    if (min_gap < 5) begin bad++; $display("FAIL dwell_gap got %0d want >=5", min_gap); end
    if (code_o !== (RZ ? 12'd0 : 12'd130)) begin bad++; $display("FAIL dwell_lastcode got %0d want %0d", code_o, RZ ? 0 : 130); end
  endtask

  task automatic test_no_dwell();
    clr();
    kick(12'd100, 12'd125, 12'd10, 16'd0);
    wait_idle();
    exp_codes = '{12'd100, 12'd110, 12'd120};
    if (RZ) exp_codes.push_back(12'd0);
    total++;
    if (frames.size() != exp_codes.size()) begin bad++; $display("FAIL nodwell_nframes got %0d want %0d", frames.size(), exp_codes.size()); end
    for (int i = 0; i < exp_codes.size() && i < frames.size(); i++) begin
      total++;
      if (frames[i] !== {4'b0011, exp_codes[i]}) begin bad++; $display("FAIL nodwell_frame%0d got %h want %h", i, frames[i], {4'b0011, exp_codes[i]}); end
    end
    total += 2;
    if (n_eov != 3) begin bad++; $display("FAIL nodwell_eov got %0d want 3", n_eov); end
    if (n_done != 1) begin bad++; $display("FAIL nodwell_done got %0d want 1", n_done); end
  endtask

  task automatic test_carry();
    clr();
    kick(12'd4090, 12'd4095, 12'd8, 16'd2);
    wait_idle();
    exp_codes = '{12'd4090};
    if (RZ) exp_codes.push_back(12'd0);
    total++;
    if (frames.size() != exp_codes.size()) begin bad++; $display("FAIL carry_nframes got %0d want %0d", frames.size(), exp_codes.size()); end
    for (int i = 0; i < exp_codes.size() && i < frames.size(); i++) begin
      total++;
      if (frames[i] !== {4'b0011, exp_codes[i]}) begin bad++; $display("FAIL carry_frame%0d got %h want %h", i, frames[i], {4'b0011, exp_codes[i]}); end
    end
    total += 2;
    if (n_eov != 1) begin bad++; $display("FAIL carry_eov got %0d want 1", n_eov); end
    if (n_done != 1) begin bad++; $display("FAIL carry_done got %0d want 1", n_done); end
  endtask

  task automatic test_degenerate();
    clr();
    kick(12'd500, 12'd600, 12'd0, 16'd1);
    wait_idle();
    total += 3;
    if (frames.size() != (RZ ? 2 : 1)) begin bad++; $display("FAIL step0_nframes got %0d want %0d", frames.size(), RZ ? 2 : 1); end
    if (frames.size() > 0 && frames[0] !== 16'h31F4) begin bad++; $display("FAIL step0_frame got %h want 31f4", frames[0]); end
    if (n_done != 1) begin bad++; $display("FAIL step0_done got %0d want 1", n_done); end
    clr();
    kick(12'd300, 12'd200, 12'd5, 16'd1);
    wait_idle();
    total += 3;
    if (frames.size() != (RZ ? 2 : 1)) begin bad++; $display("FAIL inverted_nframes got %0d want %0d", frames.size(), RZ ? 2 : 1); end
    if (frames.size() > 0 && frames[0] !== 16'h312C) begin bad++; $display("FAIL inverted_frame got %h want 312c", frames[0]); end
    if (n_done != 1) begin bad++; $display("FAIL inverted_done got %0d want 1", n_done); end
  endtask

  task automatic test_abort();
    int ns;
    int n;
    clr();
    kick(12'd100, 12'd200, 12'd10, 16'd3);
    ns = 1;
    n = 0;
    while (ns < 2 && n < 500) begin
      @(negedge clk);
      if (spi_start_o) ns++;
      n++;
    end
    total++;
    if (ns != 2) begin bad++; $display("FAIL abort_second_frame_timeout starts=%0d want 2", ns); end
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_idle();
    exp_codes = '{12'd100, 12'd110};
    if (RZ) exp_codes.push_back(12'd0);
    total++;
    if (frames.size() != exp_codes.size()) begin bad++; $display("FAIL abort_nframes got %0d want %0d", frames.size(), exp_codes.size()); end
    for (int i = 0; i < exp_codes.size() && i < frames.size(); i++) begin
      total++;
      if (frames[i] !== {4'b0011, exp_codes[i]}) begin bad++; $display("FAIL abort_frame%0d got %h want %h", i, frames[i], {4'b0011, exp_codes[i]}); end
    end
    total += 2;
    if (n_eov != 2) begin bad++; $display("FAIL abort_eov got %0d want 2", n_eov); end
    if (n_done != 0) begin bad++; $display("FAIL abort_done got %0d want 0", n_done); end
  endtask

  task automatic test_reset_mid();
    int n;
    clr();
    kick(12'd100, 12'd200, 12'd10, 16'd30);
    n = 0;
    while (!eov_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (eov_o !== 1'b1) begin bad++; $display("FAIL rstmid_eov_timeout got %b want 1", eov_o); end
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    total += 4;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    if (code_o !== 12'h0) begin bad++; $display("FAIL rstmid_code got %h want 000", code_o); end
    if (spi_data_o !== 16'h0) begin bad++; $display("FAIL rstmid_data got %h want 0000", spi_data_o); end
    if (spi_start_o !== 1'b0) begin bad++; $display("FAIL rstmid_spi_start got %b want 0", spi_start_o); end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_stays_idle got %b want 0", busy_o); end
    clr();
    kick(12'd0, 12'd20, 12'd10, 16'd2);
    wait_idle();
    exp_codes = '{12'd0, 12'd10, 12'd20};
    if (RZ) exp_codes.push_back(12'd0);
    total++;
    if (frames.size() != exp_codes.size()) begin bad++; $display("FAIL rstmid_nframes got %0d want %0d", frames.size(), exp_codes.size()); end
    for (int i = 0; i < exp_codes.size() && i < frames.size(); i++) begin
      total++;
      if (frames[i] !== {4'b0011, exp_codes[i]}) begin bad++; $display("FAIL rstmid_frame%0d got %h want %h", i, frames[i], {4'b0011, exp_codes[i]}); end
    end
    total += 2;
    if (n_eov != 3) begin bad++; $display("FAIL rstmid_eov got %0d want 3", n_eov); end
    if (n_done != 1) begin bad++; $display("FAIL rstmid_done got %0d want 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_start_abort();
    test_sweep_dwell();
    test_no_dwell();
    test_carry();
    test_degenerate();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_sweep_sequencer.md
Name: dac_sweep_sequencer

Overview:
Sequences voltage sweeps on the bolometer bias DAC by driving the existing SPI DAC write path. After one start pulse it writes codes from a start value to a stop value in fixed increments. It waits for each SPI frame to complete and holds each level for a programmable dwell time. It sits between the button/host control logic and the SPI master, replacing the current one-write-per-button scheme.

Parameters:
- DATA_W, 12, DAC code width in bits
- CMD_W, 4, DAC command field width; the SPI frame is CMD_W+DATA_W bits
- DWELL_W, 16, dwell counter width in clk_i cycles

Ports:
- clk_i  in  1  system clock, 100 MHz
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle sweep request; sampled only in IDLE
- abort_i  in  1  single-cycle abort request
- code_start_i  in  DATA_W  first code; latched on accepted start
- code_stop_i  in  DATA_W  upper bound code; latched on accepted start
- step_i  in  DATA_W  increment; latched on accepted start
- dwell_i  in  DWELL_W  hold cycles after each write; latched on accepted start
- spi_start_o  out  1  single-cycle request to the SPI master
- spi_data_o  out  CMD_W+DATA_W  frame {CMD_WRITE_UPDATE, code}
- spi_done_i  in  1  single-cycle end-of-frame pulse from the SPI master
- code_o  out  DATA_W  code most recently sent
- busy_o  out  1  high whenever state != IDLE
- eov_o  out  1  single-cycle pulse per completed write (end of voltage step)
- done_o  out  1  single-cycle pulse at normal sweep completion

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni). All outputs are registered.
- Reset values: every output is 0, state is IDLE, and all latched registers are 0.
- States: IDLE, SEND, WAIT_SPI, DWELL, NEXT, FINISH.
- IDLE:
  - When start_i=1 and abort_i=0, latch the configuration, set cur=code_start_i, and go to SEND.
  - If start_i and abort_i are both 1, abort wins and the block stays in IDLE.
- SEND:
  - spi_start_o=1 for exactly one cycle.
  - spi_data_o={CMD_WRITE_UPDATE, cur}. It is held stable until spi_done_i.
  - code_o updates to cur in this cycle.
  - Go to WAIT_SPI.
  - Latency: start_i accepted at cycle N gives spi_start_o at cycle N+1.
- WAIT_SPI:
  - On spi_done_i, pulse eov_o in the next cycle.
  - If an abort is pending, go to IDLE.
  - Else, if dwell=0, go to NEXT. Otherwise go to DWELL.
- DWELL:
  - Stay exactly dwell cycles, then go to NEXT.
  - If abort_i is seen here, go to IDLE immediately.
- NEXT:
  - Compute nxt=cur+step with DATA_W+1 bits.
  - If step=0, or nxt carries out, or nxt>stop, go to FINISH.
  - Otherwise set cur=nxt and go to SEND.
  - The last code written is the largest start+k*step that is <=stop.
  - If start>stop, exactly one frame (start) is written.
- FINISH: pulse done_o for one cycle, then go to IDLE.
- Abort rules:
  - An abort during SEND or WAIT_SPI is recorded in a sticky flag and never cuts a frame.
  - The block returns to IDLE after spi_done_i.
  - No further spi_start_o is issued after an abort, and done_o is not asserted.
  - abort_i is ignored in IDLE and FINISH.
- Ignored inputs:
  - start_i while busy_o=1 is ignored.
  - spi_done_i outside WAIT_SPI is ignored.
- Reset mid-sweep: outputs clear asynchronously and the block stays in IDLE until a new start.

Optional Feature:
- Macro: DAC_SWEEP_RETURN_ZERO_EN.
- With the macro defined: after a normal last point, and also after an abort that completes a frame, the block writes one extra frame {CMD_WRITE_UPDATE, 0} through SEND/WAIT_SPI. That frame gives no eov_o pulse. Then it goes to FINISH (normal) or IDLE (abort). This returns the bolometer bias to 0 V.
- Without the macro: the DAC holds the last code written.

Decomposition:
- Package dac_sweep_pkg holds:
  - the state enum
  - CMD_WRITE_UPDATE (4'b0011)
  - the frame-width localparam
- Natural sub-module: dac_dwell_timer. It is a loadable down-counter with inputs load/value and a single-cycle expired output.

Test Plan:
- start=100, stop=130, step=10, dwell=5: frames carry codes 100, 110, 120, 130, each with data {4'b0011, code}. Four eov_o pulses, one done_o. Gap from spi_done_i to the next spi_start_o is at least 5 cycles.
- start=100, stop=125, step=10, dwell=0: codes 100, 110, 120 only, then done_o.
- start=4090, stop=4095, step=8: a single frame (4090), because the carry-out is detected. No wrap to 2, then done_o.
- step=0, start=500: one frame. Then start=300, stop=200, step=5: one frame (300). Each gives done_o.
- abort_i asserted during WAIT_SPI of the second frame: the frame completes, no third spi_start_o, busy_o falls, done_o stays 0. With DAC_SWEEP_RETURN_ZERO_EN, one extra frame with code 0 is sent.
- rst_ni low during DWELL: all outputs are 0 immediately. Then start=0, stop=20, step=10 runs cleanly with codes 0, 10, 20.
